// File: rtl/multi_lane_judge.sv
// N-lane rhythm judgement engine: per-lane note queues, windowed press/expiry
// judgement, a lowest-lane-first result arbiter and saturating score/combo.
module multi_lane_judge #(
  parameter int LANES    = 2,
  parameter int TW       = 32,
  parameter int DEPTH    = 4,
  parameter int PERF_WIN = 30,
  parameter int GOOD_WIN = 80,
  parameter int SCORE_W  = 16,
  parameter int PERF_PTS = 2,
  parameter int GOOD_PTS = 1,
  localparam int LW      = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clear,
  input  logic [TW-1:0]      i_cur_time,
  input  logic [LANES-1:0]   i_note_vld,
  input  logic [TW-1:0]      i_note_time,
  output logic [LANES-1:0]   o_note_rdy,
  input  logic [LANES-1:0]   i_btn,
  output logic [LANES-1:0]   o_pending,
  output logic               o_judge_vld,
  output logic [1:0]         o_judge,
  output logic [LW-1:0]      o_judge_lane,
  output logic [15:0]        o_combo,
  output logic [15:0]        o_max_combo,
  output logic [SCORE_W-1:0] o_score,
  output logic               o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    J_MISS = 2'd0,
    J_GOOD = 2'd1,
    J_PERF = 2'd2
  } judge_e;

  logic [TW-1:0]      mem_q      [LANES][DEPTH];
  logic [AW-1:0]      wr_q       [LANES];
  logic [AW-1:0]      wr_d       [LANES];
  logic [AW-1:0]      rd_q       [LANES];
  logic [AW-1:0]      rd_d       [LANES];
  logic [CW-1:0]      cnt_q      [LANES];
  logic [CW-1:0]      cnt_d      [LANES];
  judge_e             slot_res_q [LANES];
  judge_e             slot_res_d [LANES];
  judge_e             load_res_s [LANES];
  logic [TW-1:0]      head_s     [LANES];
  logic [TW-1:0]      dist_s     [LANES];
  logic [LANES-1:0]   late_s;
  logic [LANES-1:0]   req_q, req_d;
  logic [LANES-1:0]   slot_vld_q, slot_vld_d;
  logic [LANES-1:0]   note_rdy_q, note_rdy_d;
  logic [LANES-1:0]   push_s, pop_s, load_s, consume_s;
  logic               ovf_s;
  logic               win_vld_s;
  logic [LW-1:0]      win_lane_s;
  judge_e             win_res_s;
  logic               judge_vld_q;
  judge_e             judge_q;
  logic [LW-1:0]      lane_q;
  logic [15:0]        combo_q, combo_d;
  logic [15:0]        max_combo_q, max_combo_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W:0]   sum_s;
  logic               ovf_q;

  // Head timing: lateness uses one extra bit so head + GOOD_WIN never wraps.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      head_s[k] = mem_q[k][rd_q[k]];
      late_s[k] = {1'b0, i_cur_time} > ({1'b0, head_s[k]} + (TW+1)'(GOOD_WIN));
      if (i_cur_time >= head_s[k]) begin
        dist_s[k] = i_cur_time - head_s[k];
      end else begin
        dist_s[k] = head_s[k] - i_cur_time;
      end
    end
  end

  // Stage 1 decisions plus queue and press-latch next state.
  always_comb begin
    pop_s      = '0;
    load_s     = '0;
    consume_s  = '0;
    push_s     = '0;
    ovf_s      = 1'b0;
    note_rdy_d = '0;
    req_d      = '0;
    for (int k = 0; k < LANES; k++) begin
      load_res_s[k] = J_MISS;
      if (!slot_vld_q[k] && (cnt_q[k] != '0) && late_s[k]) begin
        pop_s[k]  = 1'b1;
        load_s[k] = 1'b1;
      end else if (!slot_vld_q[k] && req_q[k]) begin
        consume_s[k] = 1'b1;
        if ((cnt_q[k] != '0) && (dist_s[k] <= TW'(GOOD_WIN))) begin
          pop_s[k]      = 1'b1;
          load_s[k]     = 1'b1;
          load_res_s[k] = (dist_s[k] <= TW'(PERF_WIN)) ? J_PERF : J_GOOD;
        end else begin
          load_s[k] = 1'b0;
        end
      end else begin
        consume_s[k] = 1'b0;
      end
      // A pop in the same cycle frees the slot a push into a full queue needs.
      push_s[k]     = i_note_vld[k] && ((cnt_q[k] != CW'(DEPTH)) || pop_s[k]);
      ovf_s         = ovf_s | (i_note_vld[k] & ~push_s[k]);
      req_d[k]      = (req_q[k] & ~consume_s[k]) | i_btn[k];
      wr_d[k]       = wr_q[k] + AW'(push_s[k]);
      rd_d[k]       = rd_q[k] + AW'(pop_s[k]);
      cnt_d[k]      = cnt_q[k] + CW'(push_s[k]) - CW'(pop_s[k]);
      note_rdy_d[k] = (cnt_d[k] != CW'(DEPTH));
    end
  end

  // Stage 2: lowest-index full slot wins; the winner's slot is freed.
  always_comb begin
    win_vld_s  = 1'b0;
    win_lane_s = '0;
    win_res_s  = J_MISS;
    slot_vld_d = '0;
    for (int k = LANES - 1; k >= 0; k--) begin
      win_vld_s  = win_vld_s | slot_vld_q[k];
      win_lane_s = slot_vld_q[k] ? LW'(k) : win_lane_s;
      win_res_s  = slot_vld_q[k] ? slot_res_q[k] : win_res_s;
    end
    for (int k = 0; k < LANES; k++) begin
      slot_vld_d[k] = load_s[k] | (slot_vld_q[k] & ~(win_vld_s && (win_lane_s == LW'(k))));
      slot_res_d[k] = load_s[k] ? load_res_s[k] : slot_res_q[k];
    end
  end

  // Saturating score and combo update for the emitted result.
  always_comb begin
    score_d     = score_q;
    combo_d     = combo_q;
    max_combo_d = max_combo_q;
    sum_s       = '0;
    if (win_vld_s) begin
      if (win_res_s == J_MISS) begin
        combo_d = 16'd0;
      end else begin
        sum_s   = {1'b0, score_q} + ((win_res_s == J_PERF) ? (SCORE_W+1)'(PERF_PTS)
                                                           : (SCORE_W+1)'(GOOD_PTS));
        score_d = sum_s[SCORE_W] ? {SCORE_W{1'b1}} : sum_s[SCORE_W-1:0];
        combo_d = (combo_q == 16'hFFFF) ? combo_q : (combo_q + 16'd1);
      end
      max_combo_d = (combo_d > max_combo_q) ? combo_d : max_combo_q;
    end else begin
      max_combo_d = max_combo_q;
    end
  end

  // Note storage; stale entries are harmless once the pointers reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < LANES; k++) begin
      if (push_s[k]) begin
        mem_q[k][wr_q[k]] <= i_note_time;
      end
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst || i_clear) begin
      for (int k = 0; k < LANES; k++) begin
        wr_q[k]       <= '0;
        rd_q[k]       <= '0;
        cnt_q[k]      <= '0;
        slot_res_q[k] <= J_MISS;
      end
      req_q       <= '0;
      slot_vld_q  <= '0;
      note_rdy_q  <= '1;
      judge_vld_q <= 1'b0;
      judge_q     <= J_MISS;
      lane_q      <= '0;
      combo_q     <= 16'd0;
      max_combo_q <= 16'd0;
      score_q     <= '0;
      ovf_q       <= 1'b0;
    end else begin
      for (int k = 0; k < LANES; k++) begin
        wr_q[k]       <= wr_d[k];
        rd_q[k]       <= rd_d[k];
        cnt_q[k]      <= cnt_d[k];
        slot_res_q[k] <= slot_res_d[k];
      end
      req_q       <= req_d;
      slot_vld_q  <= slot_vld_d;
      note_rdy_q  <= note_rdy_d;
      judge_vld_q <= win_vld_s;
      judge_q     <= win_res_s;
      lane_q      <= win_lane_s;
      combo_q     <= combo_d;
      max_combo_q <= max_combo_d;
      score_q     <= score_d;
      ovf_q       <= ovf_q | ovf_s;
    end
  end

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      o_pending[k] = (cnt_q[k] != '0);
    end
  end

  assign o_note_rdy   = note_rdy_q;
  assign o_judge_vld  = judge_vld_q;
  assign o_judge      = judge_q;
  assign o_judge_lane = lane_q;
  assign o_combo      = combo_q;
  assign o_max_combo  = max_combo_q;
  assign o_score      = score_q;
  assign o_overflow   = ovf_q;

endmodule

// File: tb/tb_multi_lane_judge.sv
// Directed bench for multi_lane_judge (2 lanes, depth 4, 4-bit score to reach saturation).
module tb_multi_lane_judge;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_clear;
  logic [31:0] i_cur_time;
  logic [1:0]  i_note_vld;
  logic [31:0] i_note_time;
  logic [1:0]  o_note_rdy;
  logic [1:0]  i_btn;
  logic [1:0]  o_pending;
  logic        o_judge_vld;
  logic [1:0]  o_judge;
  logic [0:0]  o_judge_lane;
  logic [15:0] o_combo;
  logic [15:0] o_max_combo;
  logic [3:0]  o_score;
  logic        o_overflow;

  int checks = 0;
  int errors = 0;

  multi_lane_judge #(
    .LANES(2), .TW(32), .DEPTH(4), .PERF_WIN(30), .GOOD_WIN(80),
    .SCORE_W(4), .PERF_PTS(2), .GOOD_PTS(1)
  ) dut (
    .clk(clk), .rst(rst), .i_clear(i_clear), .i_cur_time(i_cur_time),
    .i_note_vld(i_note_vld), .i_note_time(i_note_time), .o_note_rdy(o_note_rdy),
    .i_btn(i_btn), .o_pending(o_pending), .o_judge_vld(o_judge_vld),
    .o_judge(o_judge), .o_judge_lane(o_judge_lane), .o_combo(o_combo),
    .o_max_combo(o_max_combo), .o_score(o_score), .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] mask, input logic [31:0] t);
    i_note_vld  = mask;
    i_note_time = t;
    step();
    i_note_vld  = 2'b00;
  endtask

  task automatic hit(input logic [1:0] mask, input int j, input int lane,
                     input int sc, input int cb, input int mc);
    i_btn = mask;
    step();
    i_btn = 2'b00;
    step();
    chk("hit_no_early_strobe", o_judge_vld, 0);
    step();
    chk("hit_vld", o_judge_vld, 1);
    chk("hit_judge", o_judge, j);
    chk("hit_lane", o_judge_lane, lane);
    chk("hit_score", o_score, sc);
    chk("hit_combo", o_combo, cb);
    chk("hit_max_combo", o_max_combo, mc);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_vld"}, o_judge_vld, 0);
    chk({tag, "_judge"}, o_judge, 0);
    chk({tag, "_lane"}, o_judge_lane, 0);
    chk({tag, "_combo"}, o_combo, 0);
    chk({tag, "_max_combo"}, o_max_combo, 0);
    chk({tag, "_score"}, o_score, 0);
    chk({tag, "_overflow"}, o_overflow, 0);
    chk({tag, "_pending"}, o_pending, 0);
    chk({tag, "_note_rdy"}, o_note_rdy, 3);
  endtask

  initial begin
    rst = 1'b0; i_clear = 1'b0; i_cur_time = 32'd0;
    i_note_vld = 2'b00; i_note_time = 32'd0; i_btn = 2'b00;
    step(); step();
    rst = 1'b1;
    chk_reset_state("reset");

    // Perfect on lane 0 (d=20)
    i_cur_time = 32'd990;
    push(2'b01, 32'd1000);
    chk("push_pending", o_pending, 1);
    i_cur_time = 32'd1020;
    hit(2'b01, 2, 0, 2, 1, 1);
    step();
    chk("strobe_one_cycle", o_judge_vld, 0);

    // Good on lane 1 (d=60), then an out-of-window press is ignored (d=200)
    i_cur_time = 32'd1940;
    push(2'b10, 32'd2000);
    hit(2'b10, 1, 1, 3, 2, 2);
    push(2'b10, 32'd2140);
    i_btn = 2'b10;
    step();
    i_btn = 2'b00;
    step();
    chk("far_press_no_strobe_a", o_judge_vld, 0);
    step();
    chk("far_press_no_strobe_b", o_judge_vld, 0);
    chk("far_press_head_kept", o_pending, 2);
    chk("far_press_score", o_score, 3);
    i_cur_time = 32'd2150;
    hit(2'b10, 2, 1, 5, 3, 3);

    // Expiry: target 2500 survives at 2580, misses at 2581
    i_cur_time = 32'd2400;
    push(2'b01, 32'd2500);
    i_cur_time = 32'd2580;
    step(); step();
    chk("expiry_boundary_no_strobe", o_judge_vld, 0);
    chk("expiry_boundary_pending", o_pending, 1);
    i_cur_time = 32'd2581;
    step();
    chk("expiry_latency", o_judge_vld, 0);
    step();
    chk("miss_vld", o_judge_vld, 1);
    chk("miss_judge", o_judge, 0);
    chk("miss_lane", o_judge_lane, 0);
    chk("miss_combo", o_combo, 0);
    chk("miss_max_combo", o_max_combo, 3);
    chk("miss_score", o_score, 5);

    // Simultaneous perfect presses on both lanes: lane 0 first, lane 1 next
    i_cur_time = 32'd3000;
    push(2'b11, 32'd3010);
    i_btn = 2'b11;
    step();
    i_btn = 2'b00;
    step();
    chk("dual_no_early", o_judge_vld, 0);
    step();
    chk("dual_l0_vld", o_judge_vld, 1);
    chk("dual_l0_lane", o_judge_lane, 0);
    chk("dual_l0_judge", o_judge, 2);
    chk("dual_l0_score", o_score, 7);
    step();
    chk("dual_l1_vld", o_judge_vld, 1);
    chk("dual_l1_lane", o_judge_lane, 1);
    chk("dual_l1_judge", o_judge, 2);
    chk("dual_l1_score", o_score, 9);
    chk("dual_l1_combo", o_combo, 2);
    step();
    chk("dual_done", o_judge_vld, 0);

    // Fill lane 0, overflow on 5th push, then push+pop keeps it full
    i_cur_time = 32'd4000;
    push(2'b01, 32'd4100);
    push(2'b01, 32'd4110);
    push(2'b01, 32'd4120);
    chk("fill3_rdy", o_note_rdy, 3);
    push(2'b01, 32'd4130);
    chk("full_rdy", o_note_rdy, 2);
    chk("full_no_overflow", o_overflow, 0);
    push(2'b01, 32'd4140);
    chk("overflow_set", o_overflow, 1);
    chk("overflow_rdy", o_note_rdy, 2);
    i_cur_time = 32'd4100;
    i_btn = 2'b01;
    step();
    i_btn = 2'b00;
    push(2'b01, 32'd4150);
    chk("push_pop_still_full", o_note_rdy, 2);
    chk("push_pop_overflow_sticky", o_overflow, 1);
    step();
    chk("push_pop_vld", o_judge_vld, 1);
    chk("push_pop_judge", o_judge, 2);
    chk("push_pop_score", o_score, 11);
    chk("push_pop_combo", o_combo, 3);

    // Drain at 4180: three goods reach 14, then a perfect saturates at 15
    i_cur_time = 32'd4180;
    hit(2'b01, 1, 0, 12, 4, 4);
    hit(2'b01, 1, 0, 13, 5, 5);
    hit(2'b01, 1, 0, 14, 6, 6);
    hit(2'b01, 2, 0, 15, 7, 7);
    chk("drained_pending", o_pending, 0);
    push(2'b10, 32'd4200);
    hit(2'b10, 2, 1, 15, 8, 8);

    // Reset while a result sits in its slot: no strobe follows
    i_cur_time = 32'd5000;
    push(2'b01, 32'd5000);
    i_btn = 2'b01;
    step();
    i_btn = 2'b00;
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk_reset_state("mid_reset");
    step();
    chk("mid_reset_no_strobe", o_judge_vld, 0);

    // Synchronous clear empties queues
    push(2'b10, 32'd6000);
    chk("pre_clear_pending", o_pending, 2);
    i_clear = 1'b1;
    step();
    i_clear = 1'b0;
    chk("clear_pending", o_pending, 0);
    chk("clear_rdy", o_note_rdy, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_lane_judge.md
Name: multi_lane_judge

Overview:
- Parametrised N-lane rhythm judgement engine; replaces the fixed two-track judgement/score pair in the game top level.
- Each lane holds a FIFO of note target times pushed by the note generator.
- Button presses are judged against the head note's target time using timestamp windows, and unhit notes expire as misses.
- One judge result is emitted per cycle, with running score, combo and max-combo kept internally. Feeds the LED, segment and piezo controllers.

Parameters:
LANES, 2, number of tracks (1..8)
TW, 32, width of the game time (ms) bus
DEPTH, 4, per-lane queue depth in notes (power of 2, >=2)
PERF_WIN, 30, max |press - target| in ms for PERFECT
GOOD_WIN, 80, max |press - target| in ms for GOOD; also the miss-expiry margin (GOOD_WIN > PERF_WIN)
SCORE_W, 16, score width
PERF_PTS, 2, points for PERFECT
GOOD_PTS, 1, points for GOOD

Ports:
clk  in  1  system clock (50 MHz)
rst  in  1  synchronous reset, active-low
i_clear  in  1  synchronous restart: same effect as reset
i_cur_time  in  TW  current game time in ms, monotonic, never wraps within a song
i_note_vld  in  LANES  push i_note_time into lane k's queue
i_note_time  in  TW  target hit time; shared by all lanes pushed in the same cycle
o_note_rdy  out  LANES  lane queue not full (registered)
i_btn  in  LANES  debounced single-cycle press pulses
o_pending  out  LANES  lane queue non-empty
o_judge_vld  out  1  one-cycle result strobe
o_judge  out  2  2=PERFECT, 1=GOOD, 0=MISS; valid with o_judge_vld
o_judge_lane  out  clog2(LANES) (min 1)  lane of the result
o_combo  out  16  current combo
o_max_combo  out  16  best combo since reset/clear
o_score  out  SCORE_W  accumulated score
o_overflow  out  1  sticky: a push hit a full queue

Behaviour:
- Reset (rst=0 at a clk edge) or i_clear=1 empties all queues, press latches and pending slots.
- Reset/clear values: o_judge_vld=0, o_judge=0, o_judge_lane=0, o_combo=0, o_max_combo=0, o_score=0, o_overflow=0, o_pending=0, o_note_rdy=all ones.
- If reset/clear arrives mid-operation, any in-flight result is discarded and no strobe follows.
- Push handling:
  - A push to a full lane is dropped and sets o_overflow.
  - Push and pop on the same lane in the same cycle both take effect, so the count is unchanged.
  - A push to an empty lane is not visible to evaluation until the next cycle.
- Press latch: an i_btn pulse sets a per-lane sticky request. A further pulse while the request is set is merged into it.
- Stage 1 runs per lane, only when that lane's result slot is empty:
  - Expire: if the queue is non-empty and i_cur_time > head + GOOD_WIN, pop the head and load the slot with MISS.
  - Press: otherwise, if a request is set, clear the request. Let d = |i_cur_time - head|, computed without signed overflow by subtracting the smaller value from the larger.
    - Queue empty, or d > GOOD_WIN: the press is ignored (no pop, no result).
    - d <= PERF_WIN: pop the head and load PERFECT.
    - Otherwise: pop the head and load GOOD.
  - Expiry has priority over a press in the same cycle. The request stays set and is evaluated against the next head on the following cycle.
- Stage 2 arbiter:
  - Each cycle, the lowest-index lane with a full slot wins and is emitted as the registered outputs o_judge_vld/o_judge/o_judge_lane.
  - The winning slot is freed. Other full slots wait, so no result is ever lost.
  - Latency: press at cycle N, result strobe at N+2 when uncontended.
- Score and combo update in the same cycle as the strobe:
  - PERFECT adds PERF_PTS; GOOD adds GOOD_PTS. Score saturates at 2^SCORE_W-1.
  - PERFECT/GOOD increments the combo, saturating at 16'hFFFF. MISS sets the combo to 0.
  - o_max_combo = max(o_max_combo, new combo).
- Outputs are all registered except o_pending, which is decoded from the queue counts.

Test Plan:
- Push lane0 target 1000; press at cur=1020 -> strobe 2 cycles later with judge=2, lane=0; score=2, combo=1.
- Push lane1 target 2000; press at cur=1940 (d=60) -> judge=1, lane=1; press at 1900 on target 2100 (d=200) -> no strobe, head kept.
- Push lane0 target 500, no press; cur advances to 580 -> no strobe; at 581 -> judge=0; combo reset to 0, max_combo retained.
- Presses on lanes 0 and 1 in the same cycle, both perfect -> lane0 strobe at N+2 and lane1 strobe at N+3; score +4.
- Push 5 notes to lane0 with DEPTH=4 -> o_note_rdy[0]=0 after the 4th push, 5th dropped, o_overflow=1; push+pop in the same cycle keeps the count at 4.
- Score preloaded near max (SCORE_W=4, score=14) plus a PERFECT -> 15. Assert rst=0 during a pending result -> no strobe, all outputs at reset values.
